video_timing_gen: RTL and testbench



---
 rtl/video_timing_gen_pkg.sv | 33 +++
 rtl/video_timing_gen_if.sv | 32 +++
 rtl/video_timing_gen_pixel_divider.sv | 45 ++++
 rtl/video_timing_gen.sv | 134 +++++++++++++
 tb/tb_video_timing_gen.sv | 138 +++++++++++++
 5 files changed

// File: rtl/video_timing_gen_pkg.sv
// Shared timing constants, per-axis timing struct and tick-total helper for video_timing_gen.
// Optional build macro consumed by the generator: VIDEO_TIMING_ODD_SKIP_EN.
package video_timing_pkg;

    localparam int unsigned C_DEF_WIDTH       = 16;
    localparam int unsigned C_DEF_DIV         = 4;
    localparam int unsigned C_DEF_ACTIVE_H    = 256;
    localparam int unsigned C_DEF_FRONT_H     = 18;
    localparam int unsigned C_DEF_SYNC_H      = 25;
    localparam int unsigned C_DEF_BACK_H      = 42;
    localparam int unsigned C_DEF_ACTIVE_V    = 240;
    localparam int unsigned C_DEF_FRONT_V     = 5;
    localparam int unsigned C_DEF_SYNC_V      = 3;
    localparam int unsigned C_DEF_BACK_V      = 14;
    localparam int unsigned C_DEF_FRAME_WIDTH = 8;

    typedef struct packed {
        int unsigned active;
        int unsigned front;
        int unsigned sync;
        int unsigned back;
    } video_axis_t;

    typedef struct packed {
        video_axis_t h;
        video_axis_t v;
    } video_timing_t;

    function automatic int unsigned total_ticks(input video_axis_t axis);
        return axis.active + axis.front + axis.sync + axis.back;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Raster timing bundle driven by video_timing_gen towards the video output / PPU pipeline.
interface video_timing_gen_if #(
    parameter int unsigned P_width       = 16,
    parameter int unsigned P_frame_width = 8
);
    logic                     O_clock;
    logic                     O_rise;
    logic [P_width-1:0]       O_hcount;
    logic [P_width-1:0]       O_vcount;
    logic                     O_hsync;
    logic                     O_vsync;
    logic                     O_not_hblank;
    logic                     O_not_vblank;
    logic                     O_not_blank;
    logic                     O_line_start;
    logic                     O_frame_start;
    logic                     O_vblank_start;
    logic                     O_field;
    logic [P_frame_width-1:0] O_frame;

    modport master (
        output O_clock, O_rise, O_hcount, O_vcount, O_hsync, O_vsync,
               O_not_hblank, O_not_vblank, O_not_blank, O_line_start,
               O_frame_start, O_vblank_start, O_field, O_frame
    );

    modport slave (
        input  O_clock, O_rise, O_hcount, O_vcount, O_hsync, O_vsync,
               O_not_hblank, O_not_vblank, O_not_blank, O_line_start,
               O_frame_start, O_vblank_start, O_field, O_frame
    );
endinterface

// File: rtl/video_timing_gen_pixel_divider.sv
// Pixel tick divider: counts 0..P_div-1 while enabled, producing the pixel tick strobe
// and a roughly 50% duty pixel clock.
module pixel_divider #(
    parameter int unsigned P_div = 4
) (
    input  logic I_clock,
    input  logic I_reset,
    input  logic I_enable,
    output logic O_clock,
    output logic O_rise
);
    localparam int unsigned      C_DW   = (P_div > 2) ? $clog2(P_div) : 1;
    localparam logic [C_DW-1:0]  C_LAST = C_DW'(P_div - 1);
    localparam logic [C_DW-1:0]  C_HALF = C_DW'(P_div / 2);

    logic [C_DW-1:0] div_q;
    logic [C_DW-1:0] div_d;
    logic            rise_s;

    // Next divider phase; holds while disabled so resuming keeps the same phase.
    always_comb begin
        div_d  = div_q;
        rise_s = I_enable && (div_q == C_LAST);
        if (!I_enable) begin
            div_d = div_q;
        end else if (rise_s) begin
            div_d = {C_DW{1'b0}};
        end else begin
            div_d = div_q + C_DW'(1);
        end
    end

    // Divider state register with synchronous active-low reset.
    always_ff @(posedge I_clock) begin
        if (!I_reset) begin
            div_q <= {C_DW{1'b0}};
        end else begin
            div_q <= div_d;
        end
    end

    assign O_rise  = rise_s;
    assign O_clock = (div_q >= C_HALF);

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: pixel tick, h/v counters, sync/blank decode,
// strobes, field parity and frame counter. Optional macro: VIDEO_TIMING_ODD_SKIP_EN.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned P_width       = C_DEF_WIDTH,
    parameter int unsigned P_div         = C_DEF_DIV,
    parameter int unsigned P_active_h    = C_DEF_ACTIVE_H,
    parameter int unsigned P_front_h     = C_DEF_FRONT_H,
    parameter int unsigned P_sync_h      = C_DEF_SYNC_H,
    parameter int unsigned P_back_h      = C_DEF_BACK_H,
    parameter int unsigned P_active_v    = C_DEF_ACTIVE_V,
    parameter int unsigned P_front_v     = C_DEF_FRONT_V,
    parameter int unsigned P_sync_v      = C_DEF_SYNC_V,
    parameter int unsigned P_back_v      = C_DEF_BACK_V,
    parameter int unsigned P_hsync_pol   = 0,
    parameter int unsigned P_vsync_pol   = 0,
    parameter int unsigned P_frame_width = C_DEF_FRAME_WIDTH
) (
    input  logic                  I_clock,
    input  logic                  I_reset,
    input  logic                  I_enable,
    video_timing_gen_if.master    vid
);
    localparam video_timing_t C_T = '{
        h: '{active: P_active_h, front: P_front_h, sync: P_sync_h, back: P_back_h},
        v: '{active: P_active_v, front: P_front_v, sync: P_sync_v, back: P_back_v}
    };
    localparam int unsigned C_TICKS_H = total_ticks(C_T.h);
    localparam int unsigned C_TICKS_V = total_ticks(C_T.v);

    if ((64'(C_TICKS_H) > (64'd1 << P_width)) || (64'(C_TICKS_V) > (64'd1 << P_width))
        || (P_div < 2) || (P_div > 255)) begin : g_bad_config
        $error("video_timing_gen: illegal timing configuration");
    end

    localparam logic [P_width-1:0] C_H_LAST   = P_width'(C_TICKS_H - 1);
    localparam logic [P_width-1:0] C_V_LAST   = P_width'(C_TICKS_V - 1);
    // One extra bit so window ends equal to 2^P_width still compare correctly.
    localparam logic [P_width:0]   C_H_ACT    = (P_width+1)'(P_active_h);
    localparam logic [P_width:0]   C_HS_START = (P_width+1)'(P_active_h + P_front_h);
    localparam logic [P_width:0]   C_HS_END   = (P_width+1)'(P_active_h + P_front_h + P_sync_h);
    localparam logic [P_width:0]   C_V_ACT    = (P_width+1)'(P_active_v);
    localparam logic [P_width:0]   C_VS_START = (P_width+1)'(P_active_v + P_front_v);
    localparam logic [P_width:0]   C_VS_END   = (P_width+1)'(P_active_v + P_front_v + P_sync_v);
    localparam logic               C_HPOL     = (P_hsync_pol != 0);
    localparam logic               C_VPOL     = (P_vsync_pol != 0);

    logic [P_width-1:0]       hcount_q, hcount_d;
    logic [P_width-1:0]       vcount_q, vcount_d;
    logic                     field_q, field_d;
    logic [P_frame_width-1:0] frame_q, frame_d;
    logic                     rise_s;
    logic                     pix_clk_s;
    logic                     skip_s;
    logic                     frame_wrap_s;
    logic                     hsync_act_s;
    logic                     vsync_act_s;
    logic                     line_start_s;

    pixel_divider #(.P_div(P_div)) u_div (
        .I_clock  (I_clock),
        .I_reset  (I_reset),
        .I_enable (I_enable),
        .O_clock  (pix_clk_s),
        .O_rise   (rise_s)
    );

`ifdef VIDEO_TIMING_ODD_SKIP_EN
    localparam logic [P_width-1:0] C_H_SKIP = P_width'(C_TICKS_H - 2);
    // Odd fields end one tick early: the final pixel of the last line is dropped.
    assign skip_s = field_q && (vcount_q == C_V_LAST) && (hcount_q == C_H_SKIP);
`else
    assign skip_s = 1'b0;
`endif

    assign frame_wrap_s = skip_s || ((hcount_q == C_H_LAST) && (vcount_q == C_V_LAST));

    // Next raster position, field and frame number; advances only on a pixel tick.
    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        field_d  = field_q;
        frame_d  = frame_q;
        if (!rise_s) begin
            hcount_d = hcount_q;
        end else if (frame_wrap_s) begin
            hcount_d = {P_width{1'b0}};
            vcount_d = {P_width{1'b0}};
            field_d  = ~field_q;
            frame_d  = frame_q + P_frame_width'(1);
        end else if (hcount_q == C_H_LAST) begin
            hcount_d = {P_width{1'b0}};
            vcount_d = vcount_q + P_width'(1);
        end else begin
            hcount_d = hcount_q + P_width'(1);
        end
    end

    // Raster state registers with synchronous active-low reset.
    always_ff @(posedge I_clock) begin
        if (!I_reset) begin
            hcount_q <= {P_width{1'b0}};
            vcount_q <= {P_width{1'b0}};
            field_q  <= 1'b0;
            frame_q  <= {P_frame_width{1'b0}};
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            field_q  <= field_d;
            frame_q  <= frame_d;
        end
    end

    assign hsync_act_s  = ({1'b0, hcount_q} >= C_HS_START) && ({1'b0, hcount_q} < C_HS_END);
    assign vsync_act_s  = ({1'b0, vcount_q} >= C_VS_START) && ({1'b0, vcount_q} < C_VS_END);
    assign line_start_s = rise_s && (hcount_q == {P_width{1'b0}});

    assign vid.O_clock        = pix_clk_s;
    assign vid.O_rise         = rise_s;
    assign vid.O_hcount       = hcount_q;
    assign vid.O_vcount       = vcount_q;
    assign vid.O_hsync        = hsync_act_s ? C_HPOL : ~C_HPOL;
    assign vid.O_vsync        = vsync_act_s ? C_VPOL : ~C_VPOL;
    assign vid.O_not_hblank   = ({1'b0, hcount_q} < C_H_ACT);
    assign vid.O_not_vblank   = ({1'b0, vcount_q} < C_V_ACT);
    assign vid.O_not_blank    = vid.O_not_hblank && vid.O_not_vblank;
    assign vid.O_line_start   = line_start_s;
    assign vid.O_frame_start  = line_start_s && (vcount_q == {P_width{1'b0}});
    assign vid.O_vblank_start = line_start_s && ({1'b0, vcount_q} == C_V_ACT);
    assign vid.O_field        = field_q;
    assign vid.O_frame        = frame_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen on a reduced raster, compared every cycle
// against a position-in-frame reference model.
module tb_video_timing_gen;

    localparam int P_DIV = 4;
    localparam int AH = 8, FH = 2, SH = 3, BH = 2;
    localparam int AV = 6, FV = 1, SV = 2, BV = 1;
    localparam int TH = AH + FH + SH + BH;
    localparam int TV = AV + FV + SV + BV;
    localparam int FW = 3;

    logic clk;
    logic rst_n;
    logic en;

    int n_vec;
    int n_err;
    int n_fs;

    int m_div;
    int m_pos;
    int m_field;
    int m_frame;

    video_timing_gen_if #(.P_width(16), .P_frame_width(FW)) vif ();

    video_timing_gen #(
        .P_width(16), .P_div(P_DIV),
        .P_active_h(AH), .P_front_h(FH), .P_sync_h(SH), .P_back_h(BH),
        .P_active_v(AV), .P_front_v(FV), .P_sync_v(SV), .P_back_v(BV),
        .P_hsync_pol(1), .P_vsync_pol(0), .P_frame_width(FW)
    ) u_dut (
        .I_clock  (clk),
        .I_reset  (rst_n),
        .I_enable (en),
        .vid      (vif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int frame_len(input int field);
`ifdef VIDEO_TIMING_ODD_SKIP_EN
        return (field != 0) ? TH * TV - 1 : TH * TV;
`else
        return TH * TV + 0 * field;
`endif
    endfunction

    // One system-clock cycle: drive inputs, compare outputs against the model, advance model.
    task automatic step(input logic r, input logic e, input bit chk);
        int h, v;
        bit rise, ls;
        @(negedge clk);
        rst_n = r;
        en    = e;
        #1;
        h    = m_pos % TH;
        v    = m_pos / TH;
        rise = e && (m_div == P_DIV - 1);
        ls   = rise && (h == 0);
        if (chk) begin
            check("rise",         vif.O_rise,         rise);
            check("pix_clock",    vif.O_clock,        m_div >= P_DIV / 2);
            check("hcount",       vif.O_hcount,       h);
            check("vcount",       vif.O_vcount,       v);
            check("hsync",        vif.O_hsync,        (h >= AH + FH) && (h < AH + FH + SH));
            check("vsync",        vif.O_vsync,        !((v >= AV + FV) && (v < AV + FV + SV)));
            check("not_hblank",   vif.O_not_hblank,   h < AH);
            check("not_vblank",   vif.O_not_vblank,   v < AV);
            check("not_blank",    vif.O_not_blank,    (h < AH) && (v < AV));
            check("line_start",   vif.O_line_start,   ls);
            check("frame_start",  vif.O_frame_start,  ls && (v == 0));
            check("vblank_start", vif.O_vblank_start, ls && (v == AV));
            check("field",        vif.O_field,        m_field);
            check("frame",        vif.O_frame,        m_frame % (1 << FW));
            if (vif.O_frame_start === 1'b1) n_fs++;
        end
        if (!r) begin
            m_div = 0; m_pos = 0; m_field = 0; m_frame = 0;
        end else if (e) begin
            if (rise) begin
                m_pos++;
                if (m_pos == frame_len(m_field)) begin
                    m_pos   = 0;
                    m_field = 1 - m_field;
                    m_frame++;
                end
            end
            m_div = (m_div + 1) % P_DIV;
        end
    endtask

    initial begin
        int guard;
        n_vec = 0; n_err = 0; n_fs = 0;
        m_div = 0; m_pos = 0; m_field = 0; m_frame = 0;
        rst_n = 1'b0;
        en    = 1'b0;

        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 1400; i++) step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 37; i++)   step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 200; i++)  step(1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 8000; i++)
            step($urandom_range(0, 399) != 0, $urandom_range(0, 9) != 0, 1'b1);

        guard = 0;
        while (m_pos != 5 * TH + 4 && guard < 3000) begin
            step(1'b1, 1'b1, 1'b1);
            guard++;
        end
        check("reach_mid_frame", guard < 3000, 1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check("hcount_after_reset", vif.O_hcount, 0);
        check("frame_after_reset",  vif.O_frame,  0);
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 1'b1);

        check("frames_seen", n_fs >= 8, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
